// File: rtl/audio_pkg.sv
// Shared audio constants: silence threshold, note frequencies used by the
// music sequencer, I2S divider tap positions and the default amplitude.
package audio_pkg;

    localparam int unsigned SILENT_HZ = 20000;

    localparam int unsigned NOTE_C5 = 523;
    localparam int unsigned NOTE_D5 = 587;
    localparam int unsigned NOTE_E5 = 659;
    localparam int unsigned NOTE_F5 = 698;
    localparam int unsigned NOTE_G5 = 784;
    localparam int unsigned NOTE_A5 = 880;
    localparam int unsigned NOTE_B5 = 988;
    localparam int unsigned NOTE_C6 = 1047;

    localparam int unsigned MCLK_BIT = 1;
    localparam int unsigned SCK_BIT  = 3;
    localparam int unsigned LRCK_BIT = 8;

    localparam logic [15:0] AMP_DEFAULT = 16'h2000;

    typedef enum logic {
        DIV_IDLE,
        DIV_RUN
    } div_state_t;

    // A tone is audible only when non-zero and below the silence threshold.
    function automatic logic tone_valid(input logic [31:0] tone, input logic [31:0] silent);
        return (tone != 32'd0) && (tone < silent);
    endfunction

endpackage

// File: rtl/tone_speaker_if.sv
// Sequencer-to-speaker bundle: tone request and mute in, I2S DAC pins out.
interface tone_speaker_if;
    logic [31:0] tone;
    logic        mute;
    logic        audio_mclk;
    logic        audio_lrck;
    logic        audio_sck;
    logic        audio_sdin;

    modport master (
        output tone, mute,
        input  audio_mclk, audio_lrck, audio_sck, audio_sdin
    );

    modport slave (
        input  tone, mute,
        output audio_mclk, audio_lrck, audio_sck, audio_sdin
    );
endinterface

// File: rtl/tone_divider.sv
// 32-bit unsigned restoring divider, one quotient bit per cycle.
// start is accepted only when idle; done pulses for one cycle at the end.
module tone_divider
    import audio_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient
);

    div_state_t  state;
    logic [4:0]  iter;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] dvs;
    logic [32:0] rem_sh;
    logic        fits;

    // Shift the next dividend bit into the partial remainder and trial-compare.
    always_comb begin
        rem_sh = {rem, quo[31]};
        fits   = (rem_sh >= {1'b0, dvs});
    end

    // Divider sequencer: load on start, then 32 shift/subtract iterations.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= DIV_IDLE;
            iter  <= '0;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        quo   <= dividend;
                        dvs   <= divisor;
                        rem   <= '0;
                        iter  <= '0;
                        state <= DIV_RUN;
                    end
                end
                DIV_RUN: begin
                    // Dividend bits leave quo at the top while quotient bits enter at the bottom.
                    if (fits) begin
                        rem <= 32'(rem_sh - {1'b0, dvs});
                        quo <= {quo[30:0], 1'b1};
                    end else begin
                        rem <= rem_sh[31:0];
                        quo <= {quo[30:0], 1'b0};
                    end
                    iter <= iter + 5'd1;
                    if (iter == 5'd31) begin
                        state <= DIV_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end

    assign busy     = (state == DIV_RUN);
    assign quotient = quo;

endmodule

// File: rtl/tone_speaker.sv
// Tone-to-I2S speaker: tracks the requested tone, derives the square-wave
// half-period with an iterative divider, and serialises the sample to the DAC.
module tone_speaker
    import audio_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter logic [15:0] AMP       = AMP_DEFAULT,
    parameter int unsigned SILENT_HZ = audio_pkg::SILENT_HZ
) (
    input  logic          clk,
    input  logic          rst_n,
    tone_speaker_if.slave bus
);

    localparam logic [31:0] DIVIDEND   = 32'(CLK_HZ);
    localparam logic [31:0] SILENT_LIM = 32'(SILENT_HZ);
    localparam logic [15:0] AMP_NEG    = 16'(~AMP + 16'd1);

    logic [31:0] cur_tone;
    logic [31:0] limit;
    logic        start;
    logic        div_busy;
    logic        div_done;
    logic [31:0] quotient;

    logic [31:0] cnt;
    logic        pol;
    logic [15:0] sample;

    logic [8:0]  div;
    logic [8:0]  div_nxt;
    logic [3:0]  bit_idx;
    logic [15:0] frame_sample;
    logic        sdin;

    tone_divider u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dividend (DIVIDEND),
        .divisor  ({cur_tone[30:0], 1'b0}),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quotient)
    );

    // Tone tracking: latch a changed tone when the divider is free and either start a division or go silent.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_tone <= SILENT_LIM;
            limit    <= '0;
            start    <= 1'b0;
        end else begin
            start <= 1'b0;
            if (div_done) begin
                limit <= quotient;
            end
            // A pending start counts as busy so a second change cannot slip in before the divider accepts it.
            if ((bus.tone != cur_tone) && !div_busy && !start) begin
                cur_tone <= bus.tone;
                if (tone_valid(bus.tone, SILENT_LIM)) begin
                    start <= 1'b1;
                end else begin
                    limit <= '0;
                end
            end
        end
    end

    // Square generator: toggle polarity every limit cycles; >= tolerates a freshly reduced limit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            pol <= 1'b1;
        end else if (limit == 32'd0) begin
            cnt <= '0;
            pol <= 1'b1;
        end else if (cnt >= limit - 32'd1) begin
            cnt <= '0;
            pol <= ~pol;
        end else begin
            cnt <= cnt + 32'd1;
        end
    end

    // Sample selection: silent when muted or no tone, otherwise +/-AMP by polarity.
    always_comb begin
        sample = '0;
        if (!bus.mute && (limit != 32'd0)) begin
            sample = pol ? AMP : AMP_NEG;
        end
        div_nxt = div + 9'd1;
        bit_idx = 4'd15 - div_nxt[7:4];
    end

    // Serialiser: free-running frame divider, per-frame sample latch, sdin updated on sck falling edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div          <= '0;
            frame_sample <= '0;
            sdin         <= 1'b0;
        end else begin
            div <= div_nxt;
            if (div == '1) begin
                frame_sample <= sample;
            end
            // At the frame wrap the MSB comes straight from the sample being latched.
            if (div[3:0] == 4'hF) begin
                sdin <= (div == '1) ? sample[15] : frame_sample[bit_idx];
            end
        end
    end

    assign bus.audio_mclk = div[MCLK_BIT];
    assign bus.audio_sck  = div[SCK_BIT];
    assign bus.audio_lrck = div[LRCK_BIT];
    assign bus.audio_sdin = sdin;

endmodule
